// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard inputs from ID/EX/MEM and the
// per-stage enable/flush controls driven back to the pipeline registers.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_GPR_waddr;
  logic             ex_div_start;
  logic             exc_req;
  logic             pc_ena;
  logic             if_id_ena;
  logic             id_ex_ena;
  logic             ex_mem_ena;
  logic             mem_wb_ena;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pc_sel_exc;
  logic             div_abort;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_GPR_waddr,
           ex_div_start, exc_req,
    input  pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, if_id_flush,
           id_ex_flush, ex_mem_flush, pc_sel_exc, div_abort, div_busy, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_GPR_waddr,
           ex_div_start, exc_req,
    output pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, if_id_flush,
           id_ex_flush, ex_mem_flush, pc_sel_exc, div_abort, div_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: exception flush, multi-cycle
// divide stall, load-use bubble, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave hz
);
  localparam int DW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic {RUN, DIV_WAIT} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena;
  logic if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_exc, div_abort;

  assign load_use = hz.ex_mem_read && (hz.ex_GPR_waddr != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_GPR_waddr)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_GPR_waddr)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      div_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      stall_q   <= stall_d;
    end
  end

  // div_cnt counts the remaining DIV_WAIT cycles after the current one.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (hz.exc_req) begin
      state_d   = RUN;
      div_cnt_d = '0;
    end else if (state_q == DIV_WAIT) begin
      if (div_cnt_q == '0) state_d = RUN;
      else                 div_cnt_d = div_cnt_q - 1'b1;
    end else if (hz.ex_div_start) begin
      state_d   = DIV_WAIT;
      div_cnt_d = DW'(DIV_CYCLES - 2);
    end
  end

  always_comb begin
    pc_ena       = 1'b1;
    if_id_ena    = 1'b1;
    id_ex_ena    = 1'b1;
    ex_mem_ena   = 1'b1;
    mem_wb_ena   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel_exc   = 1'b0;
    div_abort    = 1'b0;
    if (hz.exc_req) begin
      mem_wb_ena   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      pc_sel_exc   = 1'b1;
      div_abort    = (state_q == DIV_WAIT) || hz.ex_div_start;
    end else if ((state_q == DIV_WAIT) || hz.ex_div_start) begin
      // Divide holds in EX; a bubble drains into MEM behind it.
      pc_ena       = 1'b0;
      if_id_ena    = 1'b0;
      id_ex_ena    = 1'b0;
      ex_mem_ena   = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_ena      = 1'b0;
      if_id_ena   = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall_d = (!pc_ena && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

  assign hz.pc_ena       = pc_ena;
  assign hz.if_id_ena    = if_id_ena;
  assign hz.id_ex_ena    = id_ex_ena;
  assign hz.ex_mem_ena   = ex_mem_ena;
  assign hz.mem_wb_ena   = mem_wb_ena;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.pc_sel_exc   = pc_sel_exc;
  assign hz.div_abort    = div_abort;
  assign hz.div_busy     = (state_q == DIV_WAIT);
  assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic checked
// against a remaining-stall-cycles model.
module tb_hazard_stall_ctrl;
  localparam int DIVC  = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  // {pc,if_id,id_ex,ex_mem,mem_wb ena, if_id,id_ex,ex_mem flush, pc_sel_exc, div_abort, div_busy}
  localparam logic [10:0] V_IDLE = 11'b11111_000_00_0;
  localparam logic [10:0] V_LU   = 11'b00111_010_00_0;
  localparam logic [10:0] V_DIV0 = 11'b00001_001_00_0;
  localparam logic [10:0] V_DIVW = 11'b00001_001_00_1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   m_rem  = 0;   // DIV_WAIT cycles still to come
  int   m_cnt  = 0;

  hazard_stall_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_stall_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {hif.pc_ena, hif.if_id_ena, hif.id_ex_ena, hif.ex_mem_ena, hif.mem_wb_ena,
                hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush,
                hif.pc_sel_exc, hif.div_abort, hif.div_busy};

  function automatic logic lu_f();
    return hif.ex_mem_read && (hif.ex_GPR_waddr != 5'd0) &&
           ((hif.id_uses_rs && hif.id_rs == hif.ex_GPR_waddr) ||
            (hif.id_uses_rt && hif.id_rt == hif.ex_GPR_waddr));
  endfunction

  function automatic logic [10:0] exp_vec();
    logic busy;
    busy = (m_rem > 0);
    if (hif.exc_req)
      return {5'b11110, 3'b111, 1'b1, busy || hif.ex_div_start, busy};
    if (busy || hif.ex_div_start) return {V_DIV0[10:1], busy};
    if (lu_f()) return V_LU;
    return V_IDLE;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic [4:0] wa,
                       input logic ds, input logic exc);
    hif.id_rs = rs; hif.id_rt = rt; hif.id_uses_rs = urs; hif.id_uses_rt = urt;
    hif.ex_mem_read = mr; hif.ex_GPR_waddr = wa; hif.ex_div_start = ds; hif.exc_req = exc;
    #2;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Commit the model at the clock edge, then move 1 time unit past it.
  task automatic advance();
    logic [10:0] e;
    e = exp_vec();
    if (hif.exc_req)              m_rem = 0;
    else if (m_rem > 0)           m_rem = m_rem - 1;
    else if (hif.ex_div_start)    m_rem = DIVC - 1;
    if (!e[10] && m_cnt < SMAX)   m_cnt = m_cnt + 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #5;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, V_IDLE); end
    checks++;
    if (hif.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", hif.stall_cycles); end
    m_rem = 0; m_cnt = 0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL load_use got %b want %b", obs, V_LU); end
    advance();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_clear got %b want %b", obs, V_IDLE); end
    checks++;
    if (hif.stall_cycles !== 4'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", hif.stall_cycles); end
    advance();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL load_use_r0 got %b want %b", obs, V_IDLE); end
    advance();
    drive(5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL load_use_rt got %b want %b", obs, V_LU); end
    advance();
  endtask

  task automatic test_divide();
    int c0;
    idle();
    c0 = int'(hif.stall_cycles);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (obs !== V_DIV0) begin errors++; $display("FAIL div_start got %b want %b", obs, V_DIV0); end
    advance();
    for (int i = 2; i <= DIVC; i++) begin
      // Repeated start while waiting must be ignored.
      drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, (i == 3), 1'b0);
      checks++;
      if (obs !== V_DIVW) begin errors++; $display("FAIL div_wait%0d got %b want %b", i, obs, V_DIVW); end
      advance();
    end
    idle();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL div_done got %b want %b", obs, V_IDLE); end
    checks++;
    if (int'(hif.stall_cycles) !== c0 + DIVC) begin
      errors++; $display("FAIL div_cnt got %0d want %0d", hif.stall_cycles, c0 + DIVC);
    end
    advance();
  endtask

  task automatic test_exc_mid_div();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    advance();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (obs !== 11'b11110_111_11_1) begin errors++; $display("FAIL exc_mid_div got %b want %b", obs, 11'b11110_111_11_1); end
    advance();
    idle();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL exc_after got %b want %b", obs, V_IDLE); end
    advance();
  endtask

  task automatic test_simultaneous();
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
    checks++;
    if (obs !== 11'b11110_111_11_0) begin errors++; $display("FAIL simul got %b want %b", obs, 11'b11110_111_11_0); end
    advance();
    idle();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL simul_after got %b want %b", obs, V_IDLE); end
    advance();
  endtask

  task automatic test_random();
    logic [10:0] e;
    for (int i = 0; i < 300; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0));
      e = exp_vec();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rand_out[%0d] got %b want %b", i, obs, e); end
      checks++;
      if (int'(hif.stall_cycles) !== m_cnt) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, hif.stall_cycles, m_cnt);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_div();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    advance();
    idle();
    checks++;
    if (hif.div_busy !== 1'b1) begin errors++; $display("FAIL rst_div_busy got %b want 1", hif.div_busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL rst_mid_div got %b want %b", obs, V_IDLE); end
    checks++;
    if (hif.stall_cycles !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", hif.stall_cycles); end
    m_rem = 0; m_cnt = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    idle();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL rst_after got %b want %b", obs, V_IDLE); end
    advance();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(5'd2, 5'd2, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      checks++;
      if (int'(hif.stall_cycles) !== ((i < SMAX) ? i : SMAX)) begin
        errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, hif.stall_cycles, (i < SMAX) ? i : SMAX);
      end
      advance();
    end
    idle();
    checks++;
    if (hif.stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", hif.stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_exc_mid_div();
    test_simultaneous();
    test_random();
    test_reset_mid_div();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
